// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_rsp_valid,
  output logic [DW-1:0] ifu_rsp_data,
  output logic          ifu_rsp_err,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic          lsu_we,
  input  logic [2:0]    lsu_ctr,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_rsp_valid,
  output logic [DW-1:0] lsu_rsp_data,
  output logic          lsu_rsp_err,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;
  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [2:0]    ctr_q, ctr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prio_lsu, lsu_gnt, ifu_gnt, accept, bad, rsp_v;
  logic [1:0]    off;
  logic [DW-1:0] sh, fmt;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign prio_lsu = !last_q;
  // remember who won the last accept so the other side wins the next tie
  always_comb last_d = accept ? lsu_req_ready : last_q;
  // last-grant register, starts at IFU so the first tie goes to LSU
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b0;
    else        last_q <= last_d;
`else
  assign prio_lsu = 1'b1;
`endif
  // grant and legality of the request presented this cycle
  always_comb begin
    lsu_gnt       = lsu_req_valid && (prio_lsu || !ifu_req_valid);
    ifu_gnt       = ifu_req_valid && !lsu_gnt;
    lsu_req_ready = rst_n && state_q == IDLE && lsu_gnt;
    ifu_req_ready = rst_n && state_q == IDLE && ifu_gnt;
    accept        = lsu_req_ready || ifu_req_ready;
    bad           = lsu_req_ready ?
                    (lsu_ctr == 3'b011 || lsu_ctr[2:1] == 2'b11 ||
                     (lsu_ctr[1:0] == 2'b01 && lsu_addr[0]) ||
                     (lsu_ctr[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00)) :
                    ifu_addr[1:0] != 2'b00;
  end
  // next state: latch the request, sequence issue/wait, watch the timeout
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    ctr_d   = ctr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        owner_d = lsu_req_ready;
        we_d    = lsu_req_ready && lsu_we;
        ctr_d   = lsu_req_ready ? lsu_ctr : 3'b010;
        addr_d  = lsu_req_ready ? lsu_addr : ifu_addr;
        wdata_d = lsu_req_ready ? lsu_wdata : '0;
        state_d = bad ? ERR : ISSUE;
      end
      ISSUE: if (mem_req_ready) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (mem_rsp_valid) begin
        rdata_d = mem_rdata;
        state_d = RESP;
      end else if (cnt_q == CW'(TIMEOUT)) state_d = ERR;
      else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // state and request registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      ctr_q   <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      ctr_q   <= ctr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  // memory request payload, lane-aligned read formatting and response pulses
  always_comb begin
    off           = addr_q[1:0];
    sh            = rdata_q >> {off, 3'b000};
    fmt           = we_q ? '0 : !owner_q ? rdata_q :
                    ctr_q[1:0] == 2'b00 ? {{24{~ctr_q[2] & sh[7]}}, sh[7:0]} :
                    ctr_q[1:0] == 2'b01 ? {{16{~ctr_q[2] & sh[15]}}, sh[15:0]} : sh;
    mem_req_valid = state_q == ISSUE;
    mem_we        = mem_req_valid && we_q;
    mem_addr      = mem_req_valid ? {addr_q[AW-1:2], 2'b00} : '0;
    mem_wdata     = mem_req_valid ? wdata_q << {off, 3'b000} : '0;
    mem_wmask     = !mem_we ? 4'b0000 :
                    ctr_q[1:0] == 2'b00 ? 4'b0001 << off :
                    ctr_q[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    rsp_v         = state_q == RESP || state_q == ERR;
    lsu_rsp_valid = rsp_v && owner_q;
    ifu_rsp_valid = rsp_v && !owner_q;
    lsu_rsp_err   = lsu_rsp_valid && state_q == ERR;
    ifu_rsp_err   = ifu_rsp_valid && state_q == ERR;
    lsu_rsp_data  = lsu_rsp_valid && state_q == RESP ? fmt : '0;
    ifu_rsp_data  = ifu_rsp_valid && state_q == RESP ? rdata_q : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_ctr = '0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_rsp_data;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  int          total = 0, passes = 0;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_we(lsu_we), .lsu_ctr(lsu_ctr), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] m, input bit lsu);
    chk({tag, " mvalid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, " maddr"}, mem_addr, a);
    chk({tag, " mwe"}, 32'(mem_we), 32'(w));
    chk({tag, " mmask"}, 32'(mem_wmask), 32'(m));
    if (lsu) chk({tag, " mwdata"}, mem_wdata, wd);
  endtask

  // one complete transaction; expectations derived from address/ctr rules
  task automatic xact(input bit lsu, input bit we, input logic [2:0] ctr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input int sreq, input int srsp,
                      input string tag);
    int a;
    bit bad;
    logic [31:0] sh, exp_data, exp_wd;
    logic [3:0] exp_mask;
    a = int'(addr[1:0]);
    bad = lsu ? (ctr == 3 || ctr >= 6 || (ctr % 4 == 1 && a % 2 != 0) || (ctr % 4 == 2 && a != 0)) : a != 0;
    exp_mask = (!lsu || !we) ? 4'd0 : ctr % 4 == 0 ? 4'(1 << a) : ctr % 4 == 1 ? 4'(3 << a) : 4'hf;
    exp_wd = wd << (8 * a);
    sh = rd >> (8 * a);
    case (ctr)
      3'd0: exp_data = 32'($signed(sh[7:0]));
      3'd1: exp_data = 32'($signed(sh[15:0]));
      3'd4: exp_data = 32'(sh[7:0]);
      3'd5: exp_data = 32'(sh[15:0]);
      default: exp_data = sh;
    endcase
    if (!lsu) exp_data = rd;
    else if (we) exp_data = 0;
    @(negedge clk);
    if (lsu) begin
      lsu_req_valid = 1'b1; lsu_we = we; lsu_ctr = ctr; lsu_addr = addr; lsu_wdata = wd;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end
    #1;
    chk({tag, " ready"}, 32'(lsu ? lsu_req_ready : ifu_req_ready), 32'd1);
    @(negedge clk);
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
    lsu_addr = $urandom; lsu_wdata = $urandom; ifu_addr = $urandom; lsu_we = 1'($urandom);
    #1;
    if (bad) begin
      chk({tag, " err valid"}, 32'(lsu ? lsu_rsp_valid : ifu_rsp_valid), 32'd1);
      chk({tag, " err flag"}, 32'(lsu ? lsu_rsp_err : ifu_rsp_err), 32'd1);
      chk({tag, " err data"}, lsu ? lsu_rsp_data : ifu_rsp_data, 32'd0);
      chk({tag, " err nomem"}, 32'(mem_req_valid), 32'd0);
      @(negedge clk);
      chk({tag, " err once"}, 32'(lsu_rsp_valid | ifu_rsp_valid), 32'd0);
      return;
    end
    for (int i = 0; i < sreq; i++) begin
      chk_mem({tag, " stall"}, addr & ~32'd3, lsu & we, exp_wd, exp_mask, lsu);
      @(negedge clk);
    end
    chk_mem(tag, addr & ~32'd3, lsu & we, exp_wd, exp_mask, lsu);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk({tag, " wait idle"}, {31'd0, mem_req_valid} | mem_addr | 32'(mem_wmask), 32'd0);
    for (int i = 0; i < srsp; i++) @(negedge clk);
    chk({tag, " no early rsp"}, 32'(lsu_rsp_valid | ifu_rsp_valid), 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rdata = $urandom;
    chk({tag, " rsp valid"}, 32'(lsu ? lsu_rsp_valid : ifu_rsp_valid), 32'd1);
    chk({tag, " rsp other"}, 32'(lsu ? ifu_rsp_valid : lsu_rsp_valid), 32'd0);
    chk({tag, " rsp err"}, 32'(lsu ? lsu_rsp_err : ifu_rsp_err), 32'd0);
    chk({tag, " rsp data"}, lsu ? lsu_rsp_data : ifu_rsp_data, exp_data);
    @(negedge clk);
    chk({tag, " rsp once"}, 32'(lsu_rsp_valid | ifu_rsp_valid) | lsu_rsp_data | ifu_rsp_data, 32'd0);
  endtask

  initial begin
    int n;
    bit lsu_first;
    // reset state
    @(negedge clk);
    lsu_req_valid = 1'b1; ifu_req_valid = 1'b1;
    #1;
    chk("reset ready", {30'd0, lsu_req_ready, ifu_req_ready}, 32'd0);
    chk("reset outs", {29'd0, mem_req_valid, lsu_rsp_valid, ifu_rsp_valid} | mem_addr | mem_wdata, 32'd0);
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // directed cases from the test plan
    xact(0, 0, 3'd2, 32'h8000_0004, 32'd0, 32'hDEAD_BEEF, 0, 0, "ifu fetch");
    xact(1, 0, 3'd0, 32'h8000_0013, 32'd0, 32'h80FF_1234, 0, 0, "lb");
    xact(1, 0, 3'd4, 32'h8000_0013, 32'd0, 32'h80FF_1234, 0, 0, "lbu");
    xact(1, 1, 3'd1, 32'h8000_0102, 32'h0000_ABCD, 32'h1111_2222, 0, 0, "sh");
    xact(1, 0, 3'd1, 32'h8000_0101, 32'd0, 32'd0, 0, 0, "sh misalign");
    xact(1, 0, 3'd3, 32'h8000_0100, 32'd0, 32'd0, 0, 0, "illegal ctr");
    xact(0, 0, 3'd2, 32'h8000_0002, 32'd0, 32'd0, 0, 0, "ifu misalign");
    // timeout, then a late response must be dropped
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    chk("to issue", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    n = 0;
    while (!ifu_rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("to latency", 32'(n), 32'd9);
    chk("to err", 32'(ifu_rsp_err), 32'd1);
    chk("to data", ifu_rsp_data, 32'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("late rsp dropped", {29'd0, mem_req_valid, lsu_rsp_valid, ifu_rsp_valid}, 32'd0);
    xact(0, 0, 3'd2, 32'h8000_0044, 32'd0, 32'hCAFE_F00D, 0, 0, "after to");
    // reset in the middle of WAIT
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080;
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; rst_n = 1'b0;
    #1;
    chk("rst ready", {30'd0, lsu_req_ready, ifu_req_ready}, 32'd0);
    chk("rst outs", {29'd0, mem_req_valid, lsu_rsp_valid, ifu_rsp_valid} | mem_addr | 32'(mem_wmask), 32'd0);
    @(negedge clk);
    chk("rst hold", {28'd0, lsu_req_ready, ifu_req_ready, lsu_rsp_valid, ifu_rsp_valid}, 32'd0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rst no rsp", {30'd0, lsu_rsp_valid, ifu_rsp_valid}, 32'd0);
    xact(0, 0, 3'd2, 32'h8000_0080, 32'd0, 32'h0BAD_CAFE, 0, 0, "after rst");
    // contention from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_ctr = 3'd2; lsu_addr = 32'h8000_0100;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      lsu_first = (i % 2) == 0;
`else
      lsu_first = 1'b1;
`endif
      #1;
      chk("grant", {30'd0, lsu_req_ready, ifu_req_ready}, lsu_first ? 32'd2 : 32'd1);
      @(negedge clk);
      chk("grant addr", mem_addr, lsu_first ? 32'h8000_0100 : 32'h8000_0200);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h100 + 32'(i);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("grant rsp", {30'd0, lsu_rsp_valid, ifu_rsp_valid}, lsu_first ? 32'd2 : 32'd1);
      chk("grant data", lsu_first ? lsu_rsp_data : ifu_rsp_data, 32'h100 + 32'(i));
      @(negedge clk);
    end
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      bit l, w;
      logic [31:0] ad;
      l = 1'($urandom);
      w = 1'($urandom);
      ad = 32'h8000_0000 | ($urandom & 32'hFFFF);
      if (!l && $urandom_range(0, 7) != 0) ad = ad & ~32'd3;
      xact(l, w, 3'($urandom_range(0, 7)), ad, $urandom, $urandom,
           $urandom_range(0, 2), $urandom_range(0, 3), "rand");
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
